spi_host_seq: RTL and testbench
===============================

SPI_HOST_SEQ -- requirements
Module: spi_host_seq

Interface
REQ-001 SHALL have parameter CLKDIV, default 2, meaning the SCLK half-period in clk cycles; legal range 1..255.
REQ-002 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  in  1  transaction request, sampled only when busy=0.
REQ-005 SHALL have port rw  in  1  1=read, 0=write; latched with start.
REQ-006 SHALL have port addr  in  7  target address; latched with start.
REQ-007 SHALL have port wdata  in  8  write data; latched with start.
REQ-008 SHALL have port busy  out  1  transaction or CS guard in progress.
REQ-009 SHALL have port done  out  1  one-clk pulse at transaction end.
REQ-010 SHALL have port rdata  out  8  last read byte.
REQ-011 SHALL have port cs  out  1  chip select, active-low.
REQ-012 SHALL have port sclk  out  1  serial clock, idle low.
REQ-013 SHALL have port mosi  out  1  serial data to peripheral.
REQ-014 SHALL have port miso  in  1  serial data from peripheral.

Function
REQ-015 SHALL implement states IDLE, LEAD, SHIFT, TRAIL, GUARD. Transitions: IDLE->LEAD on accepted start; LEAD->SHIFT after CLKDIV cycles; SHIFT->TRAIL after the 16th falling edge; TRAIL->GUARD after CLKDIV cycles; GUARD->IDLE after CLKDIV cycles.
REQ-016 SHALL accept start only in IDLE and latch rw/addr/wdata that cycle (cycle 0). Start in any other state is ignored.
REQ-017 SHALL frame exactly 16 bits, MSB first: addr[6:0], then rw, then 8 data bits.
REQ-018 SHALL drive cs low from cycle 1 through the TRAIL state; busy high from cycle 1 until the return to IDLE.
REQ-019 SHALL drive mosi with the first bit (addr[6]) from cycle 1, and change mosi only on sclk falling edges.
REQ-020 SHALL place sclk rising edges at cycle 1+CLKDIV+2*CLKDIV*k, for k=0..15; each falling edge follows CLKDIV cycles later.
REQ-021 SHALL, when rw=0, drive wdata[7:0] on bits 8..15.
REQ-022 SHALL, when rw=1, hold mosi=0 during bits 8..15 and sample miso on rising edges 8..15 into a shift register, MSB first.
REQ-023 SHALL raise cs and pulse done in the same cycle, at cycle 1+33*CLKDIV.
REQ-024 SHALL update rdata in the done cycle, only for reads; writes leave rdata unchanged.
REQ-025 SHALL hold cs high for CLKDIV cycles in GUARD (busy=1), then drop busy; the minimum cs-high time between transactions is therefore CLKDIV cycles.
REQ-026 SHALL drive mosi=0 whenever cs=1.
REQ-027 SHALL use a bit counter of 5 bits and a divider counter of 8 bits, with no wrap-around beyond bit 16.
REQ-028 SHALL, for an accepted start in the cycle busy falls, begin a new transaction with no extra gap.

Reset
REQ-029 SHALL, on rst_n low, immediately and asynchronously force cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=8'h00, state=IDLE, and clear all counters.
REQ-030 SHALL, if reset occurs mid-transaction, abort the transaction with no done pulse and no rdata update; the first start after rst_n rises SHALL behave as from power-up.
REQ-031 SHALL, while rst_n is low, ignore start.

Verification
REQ-032 Write, CLKDIV=2, start with addr=7'h25, rw=0, wdata=8'hA5 at cycle 0 -> mosi at the 16 rising edges = 0100101 0 10100101; cs low on cycles 1..66; done=1 at cycle 67 only; busy falls at cycle 69; rdata stays 00.
REQ-033 Read, CLKDIV=2, start with addr=7'h7F, rw=1; peripheral model drives 8'h3C on miso in the data phase -> bit 7 of the frame = 1; mosi=0 on bits 8..15; rdata=8'h3C at cycle 67 with done.
REQ-034 CLKDIV=1 write -> sclk toggles every clk, 16 rising edges at cycles 2,4,...,32; done at cycle 34; cs high for 1 cycle before busy falls.
REQ-035 start pulsed at cycles 10 and 40 during a transaction -> both ignored, with exactly one done; start held high continuously -> back-to-back transactions separated by CLKDIV cs-high cycles.
REQ-036 rst_n low at the 5th rising edge of a read -> cs=1, sclk=0, mosi=0, busy=0 in the same cycle; no done; rdata=00; a following write completes per REQ-032 timing.
REQ-037 Power-up reset check -> all outputs at REQ-029 values before the first start.

Source files
------------

// File: rtl/spi_host_seq.sv
// SPI host sequencer: one 16-bit frame {addr[6:0], rw, data[7:0]}, MSB first, SPI mode 0.
// CS lead/trail/guard phases are each CLKDIV clk cycles long.
`default_nettype none

module spi_host_seq #(
    parameter int CLKDIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       cs,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        SHIFT = 3'd2,
        TRAIL = 3'd3,
        GUARD = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  bit_q, bit_d;
    logic [15:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic        rw_q, rw_d;
    logic        cs_q, cs_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        div_last;

    assign div_last = (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rw_d    = rw_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LEAD;
                    tx_d    = {addr, rw, (rw ? 8'h00 : wdata)};
                    rw_d    = rw;
                    rx_d    = 8'h00;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = addr[6];
                    div_d   = 8'd0;
                    bit_d   = 5'd0;
                end
            end
            LEAD: begin
                if (div_last) begin
                    div_d   = 8'd0;
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                if (div_last) begin
                    div_d  = 8'd0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        // Rising edge: capture the data phase (bits 8..15) of reads only.
                        if (rw_q && bit_q[3]) begin
                            rx_d = {rx_q[6:0], miso};
                        end
                    end else begin
                        bit_d  = bit_q + 5'd1;
                        tx_d   = {tx_q[14:0], 1'b0};
                        mosi_d = tx_q[14];
                        if (bit_q == 5'd15) begin
                            state_d = TRAIL;
                            mosi_d  = 1'b0;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            TRAIL: begin
                if (div_last) begin
                    div_d   = 8'd0;
                    state_d = GUARD;
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    if (rw_q) begin
                        rdata_d = rx_q;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            GUARD: begin
                if (div_last) begin
                    div_d   = 8'd0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= 8'd0;
            bit_q   <= 5'd0;
            tx_q    <= 16'h0000;
            rx_q    <= 8'h00;
            rw_q    <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rw_q    <= rw_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign cs    = cs_q;
    assign sclk  = sclk_q;
    assign mosi  = mosi_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_host_seq.sv
// Bench for spi_host_seq: instance 0 uses CLKDIV=2, instance 1 uses CLKDIV=1.
`default_nettype none

module tb_spi_host_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       st [2];
    logic       rwv[2];
    logic [6:0] ad [2];
    logic [7:0] wd [2];
    logic       mi [2];
    logic       bz [2];
    logic       dn [2];
    logic [7:0] rd [2];
    logic       csn[2];
    logic       sc [2];
    logic       mo [2];

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_rd[2];

    spi_host_seq #(.CLKDIV(2)) u_div2 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .rw(rwv[0]), .addr(ad[0]),
        .wdata(wd[0]), .busy(bz[0]), .done(dn[0]), .rdata(rd[0]), .cs(csn[0]),
        .sclk(sc[0]), .mosi(mo[0]), .miso(mi[0])
    );

    spi_host_seq #(.CLKDIV(1)) u_div1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .rw(rwv[1]), .addr(ad[1]),
        .wdata(wd[1]), .busy(bz[1]), .done(dn[1]), .rdata(rd[1]), .cs(csn[1]),
        .sclk(sc[1]), .mosi(mo[1]), .miso(mi[1])
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input int s, input string tag);
        chk($sformatf("%s i%0d cs", tag, s),    8'(csn[s]), 8'h01);
        chk($sformatf("%s i%0d sclk", tag, s),  8'(sc[s]),  8'h00);
        chk($sformatf("%s i%0d mosi", tag, s),  8'(mo[s]),  8'h00);
        chk($sformatf("%s i%0d busy", tag, s),  8'(bz[s]),  8'h00);
        chk($sformatf("%s i%0d done", tag, s),  8'(dn[s]),  8'h00);
        chk($sformatf("%s i%0d rdata", tag, s), rd[s],      exp_rd[s]);
    endtask

    // Entered at the falling edge of an idle cycle (cycle 0); returns in the last
    // guard cycle. The expected waveform is derived from the cycle arithmetic of
    // the frame: rise k at 1+D+2Dk, bit j on mosi during cycles 1+2Dj..2D(j+1).
    task automatic txn(input int s, input logic r, input logic [6:0] a, input logic [7:0] w,
                       input logic [7:0] mb, input bit poke, input bit keep);
        int          d;
        int          falls;
        logic        prev_sclk;
        logic [15:0] frame;
        logic        e_busy, e_done, e_cs, e_sclk;
        d     = (s == 0) ? 2 : 1;
        frame = {a, r, (r ? 8'h00 : w)};
        chk($sformatf("i%0d c0 busy", s), 8'(bz[s]),  8'h00);
        chk($sformatf("i%0d c0 cs", s),   8'(csn[s]), 8'h01);
        st[s] = 1'b1; rwv[s] = r; ad[s] = a; wd[s] = w; mi[s] = 1'b0;
        falls = 0;
        prev_sclk = 1'b0;
        for (int c = 1; c <= 34 * d; c++) begin
            @(negedge clk);
            st[s] = keep || (poke && (c == 10 || c == 40));
            if (poke && (c == 10 || c == 40)) begin
                rwv[s] = ~r;
                ad[s]  = ~a;
                wd[s]  = ~w;
            end
            if (prev_sclk && !sc[s]) falls++;
            prev_sclk = sc[s];
            mi[s] = (falls >= 8 && falls <= 15) ? mb[15 - falls] : 1'b0;

            e_busy = (c >= 1) && (c <= 34 * d);
            e_done = (c == 1 + 33 * d);
            e_cs   = !((c >= 1) && (c <= 33 * d));
            e_sclk = (c >= 1 + d) && (c <= 32 * d) && (((c - 1 - d) / d) % 2 == 0);
            if (e_done && r) exp_rd[s] = mb;

            chk($sformatf("i%0d c%0d busy", s, c), 8'(bz[s]),  8'(e_busy));
            chk($sformatf("i%0d c%0d done", s, c), 8'(dn[s]),  8'(e_done));
            chk($sformatf("i%0d c%0d cs", s, c),   8'(csn[s]), 8'(e_cs));
            chk($sformatf("i%0d c%0d sclk", s, c), 8'(sc[s]),  8'(e_sclk));
            if (c <= 32 * d)
                chk($sformatf("i%0d c%0d mosi", s, c), 8'(mo[s]), 8'(frame[15 - (c - 1) / (2 * d)]));
            else if (e_cs)
                chk($sformatf("i%0d c%0d mosi_cs_high", s, c), 8'(mo[s]), 8'h00);
            chk($sformatf("i%0d c%0d rdata", s, c), rd[s], exp_rd[s]);
        end
    endtask

    initial begin
        logic       r;
        logic [6:0] a;
        logic [7:0] w;
        logic [7:0] mb;
        int         s;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; rwv[i] = 1'b0; ad[i] = 7'h00; wd[i] = 8'h00; mi[i] = 1'b0;
            exp_rd[i] = 8'h00;
        end
        st[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle(0, "por_in_reset");
        chk_idle(1, "por_in_reset");
        st[0] = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle(0, "por");
        chk_idle(1, "por");

        // Directed write and read at CLKDIV=2, directed write at CLKDIV=1.
        txn(0, 1'b0, 7'h25, 8'hA5, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk_idle(0, "after_write");
        txn(0, 1'b1, 7'h7F, 8'h00, 8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        chk_idle(0, "after_read");
        txn(1, 1'b0, 7'h25, 8'hA5, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk_idle(1, "after_div1_write");

        // Starts pulsed mid-transaction must be ignored.
        txn(0, 1'b1, 7'h11, 8'h00, 8'hC3, 1'b1, 1'b0);
        @(negedge clk);
        chk_idle(0, "after_poke");
        repeat (3) @(negedge clk);
        chk_idle(0, "quiet_after_poke");

        // Randomized transactions on both divider settings.
        for (int n = 0; n < 10; n++) begin
            s  = int'($urandom_range(0, 1));
            r  = 1'($urandom);
            a  = 7'($urandom);
            w  = 8'($urandom);
            mb = 8'($urandom);
            txn(s, r, a, w, mb, 1'b0, 1'b0);
            @(negedge clk);
        end

        // Start held high: back-to-back frames with only the guard/idle gap.
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 3; n++) begin
                r  = 1'($urandom);
                a  = 7'($urandom);
                w  = 8'($urandom);
                mb = 8'($urandom);
                txn(i, r, a, w, mb, 1'b0, (n < 2));
                @(negedge clk);
            end
            chk_idle(i, "after_b2b");
        end

        // Reset in the middle of a read: outputs drop asynchronously, no done.
        st[0] = 1'b1; rwv[0] = 1'b1; ad[0] = 7'h5A; mi[0] = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            st[0] = 1'b0;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        chk_idle(0, "async_reset");
        chk_idle(1, "async_reset");
        @(negedge clk);
        st[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_idle(0, "start_in_reset");
        end
        st[0] = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk_idle(0, "post_reset_quiet");
        end
        txn(0, 1'b0, 7'h25, 8'hA5, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk_idle(0, "final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
